// File: rtl/alu_pkg.sv
// alu_pkg
// Shared encodings for the execute block:
//   - aluop classes driven by main control
//   - R-type function field codes
//   - decoded ALU operation codes (gout)
package alu_pkg;

    // Main-control ALU operation classes {aluop2,aluop1,aluop0}
    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_RTYPE = 3'b010;
    localparam logic [2:0] ALUOP_OR    = 3'b011;
    localparam logic [2:0] ALUOP_NAND  = 3'b100;
    localparam logic [2:0] ALUOP_AND   = 3'b101;
    localparam logic [2:0] ALUOP_SLT   = 3'b110;
    localparam logic [2:0] ALUOP_ADD2  = 3'b111;

    // R-type function field codes (instruction bits [3:0])
    localparam logic [3:0] FUNCT_ADD = 4'b0000;
    localparam logic [3:0] FUNCT_SUB = 4'b0010;
    localparam logic [3:0] FUNCT_AND = 4'b0100;
    localparam logic [3:0] FUNCT_OR  = 4'b0101;
    localparam logic [3:0] FUNCT_XOR = 4'b0110;
    localparam logic [3:0] FUNCT_NOR = 4'b0111;
    localparam logic [3:0] FUNCT_SLT = 4'b1010;

    // Decoded ALU operations
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_NOR  = 4'b1100;
    localparam logic [3:0] OP_NAND = 4'b1101;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode
// Purely combinational ALU-control decode.
// Ports:
//   aluop  in  3  operation class from main control
//   funct  in  4  R-type function field, only used when aluop selects R-type
//   gout   out 4  decoded ALU operation code
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [2:0] aluop,
    input  logic [3:0] funct,
    output logic [3:0] gout
);

    always_comb begin
        gout = OP_ADD;
        unique case (aluop)
            ALUOP_ADD:   gout = OP_ADD;
            ALUOP_SUB:   gout = OP_SUB;
            ALUOP_OR:    gout = OP_OR;
            ALUOP_NAND:  gout = OP_NAND;
            ALUOP_AND:   gout = OP_AND;
            ALUOP_SLT:   gout = OP_SLT;
            ALUOP_ADD2:  gout = OP_ADD;
            ALUOP_RTYPE: begin
                // Unlisted function codes fall back to ADD
                case (funct)
                    FUNCT_ADD: gout = OP_ADD;
                    FUNCT_SUB: gout = OP_SUB;
                    FUNCT_AND: gout = OP_AND;
                    FUNCT_OR:  gout = OP_OR;
                    FUNCT_XOR: gout = OP_XOR;
                    FUNCT_NOR: gout = OP_NOR;
                    FUNCT_SLT: gout = OP_SLT;
                    default:   gout = OP_ADD;
                endcase
            end
            default:     gout = OP_ADD;
        endcase
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
// Execute-stage datapath: ALU-control decode, WIDTH-bit ALU with zero detect,
// Z/N/V status register, and the free-standing PC+4 / branch-target adder.
// Ports:
//   clk, reset       clock; synchronous active-high reset of the flags only
//   aluop, funct     operation selection (decoded by alu_op_decode)
//   a, b             ALU operands
//   flag_we          load Z/N/V from this cycle's ALU result
//   add_a, add_b     adder operands
//   gout             decoded operation (combinational)
//   result, zout     ALU result and result==0 (combinational)
//   add_sum          add_a + add_b mod 2^WIDTH (combinational)
//   zflag/nflag/vflag registered status flags
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       aluop,
    input  logic [3:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flag_we,
    input  logic [WIDTH-1:0] add_a,
    input  logic [WIDTH-1:0] add_b,
    output logic [3:0]       gout,
    output logic [WIDTH-1:0] result,
    output logic             zout,
    output logic [WIDTH-1:0] add_sum,
    output logic             zflag,
    output logic             nflag,
    output logic             vflag
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt;
    logic             ovf;

    alu_op_decode u_decode (
        .aluop (aluop),
        .funct (funct),
        .gout  (gout)
    );

    assign sum  = a + b;
    assign diff = a - b;
    assign lt   = $signed(a) < $signed(b);

    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (gout)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOR:  result = ~(a | b);
            OP_NAND: result = ~(a & b);
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt};
            OP_ADD: begin
                result = sum;
                // Like-signed operands producing an opposite-signed sum
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff;
                // Unlike-signed operands where the sign of a is lost
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            default: result = '0;
        endcase
    end

    assign zout    = (result == '0);
    assign add_sum = add_a + add_b;

    always_ff @(posedge clk) begin
        if (reset) begin
            zflag <= 1'b0;
            nflag <= 1'b0;
            vflag <= 1'b0;
        end else if (flag_we) begin
            zflag <= zout;
            nflag <= result[WIDTH-1];
            vflag <= ovf;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
// Directed vectors with hand-computed expectations for alu_exec_unit.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a, b;
    logic        flag_we;
    logic [31:0] add_a, add_b;
    logic [3:0]  gout;
    logic [31:0] result;
    logic        zout;
    logic [31:0] add_sum;
    logic        zflag, nflag, vflag;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .aluop   (aluop),
        .funct   (funct),
        .a       (a),
        .b       (b),
        .flag_we (flag_we),
        .add_a   (add_a),
        .add_b   (add_b),
        .gout    (gout),
        .result  (result),
        .zout    (zout),
        .add_sum (add_sum),
        .zflag   (zflag),
        .nflag   (nflag),
        .vflag   (vflag)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drive operands mid-cycle, then let combinational outputs settle
    task automatic drive(input logic [2:0] op, input logic [3:0] fn,
                         input logic [31:0] va, input logic [31:0] vb, input logic we);
        @(negedge clk);
        aluop   = op;
        funct   = fn;
        a       = va;
        b       = vb;
        flag_we = we;
        #1;
    endtask

    task automatic comb(input string tag, input logic [3:0] eg, input logic [31:0] er, input logic ez);
        check({tag, ".gout"},   {28'd0, gout}, {28'd0, eg});
        check({tag, ".result"}, result, er);
        check({tag, ".zout"},   {31'd0, zout}, {31'd0, ez});
    endtask

    task automatic flags(input string tag, input logic ez, input logic en, input logic ev);
        @(posedge clk);
        #1;
        check({tag, ".zflag"}, {31'd0, zflag}, {31'd0, ez});
        check({tag, ".nflag"}, {31'd0, nflag}, {31'd0, en});
        check({tag, ".vflag"}, {31'd0, vflag}, {31'd0, ev});
    endtask

    initial begin
        reset = 1'b1; flag_we = 1'b0; aluop = 3'b000; funct = 4'b0000;
        a = 32'd0; b = 32'd0; add_a = 32'd0; add_b = 32'd0;

        // Reset clears flags; combinational path still live during reset
        drive(3'b000, 4'b0000, 32'd2, 32'd3, 1'b0);
        flags("reset", 1'b0, 1'b0, 1'b0);
        check("reset.comb", result, 32'd5);
        reset = 1'b0;

        // ADD and the PC adder
        drive(3'b000, 4'b0000, 32'd5, 32'd7, 1'b0);
        add_a = 32'h10; add_b = 32'd4; #1;
        comb("add", 4'b0010, 32'd12, 1'b0);
        check("add_sum", add_sum, 32'h14);
        add_a = 32'hFFFF_FFFC; add_b = 32'd8; #1;
        check("add_sum.wrap", add_sum, 32'h4);

        // SUB to zero, flags Z
        drive(3'b001, 4'b0000, 32'h1234, 32'h1234, 1'b1);
        comb("sub0", 4'b0110, 32'd0, 1'b1);
        flags("sub0", 1'b1, 1'b0, 1'b0);

        // ADD signed overflow
        drive(3'b000, 4'b0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        comb("addovf", 4'b0010, 32'hFFFF_FFFE, 1'b0);
        flags("addovf", 1'b0, 1'b1, 1'b1);

        // SUB signed overflow
        drive(3'b001, 4'b0000, 32'h8000_0000, 32'd1, 1'b1);
        comb("subovf", 4'b0110, 32'h7FFF_FFFF, 1'b0);
        flags("subovf", 1'b0, 1'b0, 1'b1);

        // Non-arithmetic op never sets V even with sign bits set
        drive(3'b101, 4'b0000, 32'h8000_0000, 32'h8000_0000, 1'b1);
        comb("and", 4'b0000, 32'h8000_0000, 1'b0);
        flags("and", 1'b0, 1'b1, 1'b0);

        // R-type function decode
        drive(3'b010, 4'b1010, 32'hFFFF_FFFF, 32'd1, 1'b0);
        comb("r.slt", 4'b0111, 32'd1, 1'b0);
        drive(3'b010, 4'b0111, 32'd0, 32'd0, 1'b0);
        comb("r.nor", 4'b1100, 32'hFFFF_FFFF, 1'b0);
        drive(3'b010, 4'b0110, 32'hF0, 32'hFF, 1'b0);
        comb("r.xor", 4'b0011, 32'h0F, 1'b0);
        drive(3'b010, 4'b1111, 32'd3, 32'd4, 1'b0);
        comb("r.dflt", 4'b0010, 32'd7, 1'b0);
        drive(3'b010, 4'b0010, 32'd10, 32'd3, 1'b0);
        comb("r.sub", 4'b0110, 32'd7, 1'b0);
        drive(3'b010, 4'b0100, 32'hFF00, 32'h0FF0, 1'b0);
        comb("r.and", 4'b0000, 32'h0F00, 1'b0);
        drive(3'b010, 4'b0101, 32'hFF00, 32'h0FF0, 1'b0);
        comb("r.or", 4'b0001, 32'hFFF0, 1'b0);

        // Remaining aluop classes
        drive(3'b100, 4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        comb("nand", 4'b1101, 32'd0, 1'b1);
        drive(3'b011, 4'b0000, 32'h0000_00A0, 32'h0000_000B, 1'b0);
        comb("or", 4'b0001, 32'hAB, 1'b0);
        drive(3'b110, 4'b0000, 32'd1, 32'hFFFF_FFFF, 1'b0);
        comb("slt.neg", 4'b0111, 32'd0, 1'b1);
        drive(3'b111, 4'b0000, 32'd100, 32'd23, 1'b0);
        comb("add2", 4'b0010, 32'd123, 1'b0);

        // Set N, then reset wins over flag_we
        drive(3'b000, 4'b0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1);
        flags("preRst", 1'b0, 1'b1, 1'b1);
        reset = 1'b1;
        flags("rstPri", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // Set N again, then flags hold with flag_we low
        drive(3'b001, 4'b0000, 32'd0, 32'd1, 1'b1);
        flags("setN", 1'b0, 1'b1, 1'b0);
        drive(3'b001, 4'b0000, 32'd9, 32'd9, 1'b0);
        flags("hold1", 1'b0, 1'b1, 1'b0);
        drive(3'b000, 4'b0000, 32'h7FFF_FFFF, 32'd1, 1'b0);
        flags("hold2", 1'b0, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
